// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - read-side burst drain engine with 2-entry output buffer
//
// Pulls words from a show-ahead dual-clock FIFO read port in bursts of up to
// BURST_LEN words and presents them on a valid/ready stream. A partially
// filled FIFO (aempty high) is drained after TIMEOUT cycles of waiting.

module fifo_rd_drain #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 16
) (
  input  logic                           rclk,
  input  logic                           rrst_n,
  input  logic                           enable,
  input  logic                           rempty,
  input  logic                           aempty,
  input  logic [DW-1:0]                  rdata,
  output logic                           rinc,
  output logic                           m_valid,
  output logic [DW-1:0]                  m_data,
  input  logic                           m_ready,
  output logic                           busy,
  output logic                           burst_done,
  output logic [$clog2(BURST_LEN+1)-1:0] burst_words,
  output logic [CNT_W-1:0]               drained_cnt
);

  localparam int BW_W = $clog2(BURST_LEN + 1);
  localparam int TW   = $clog2(TIMEOUT) + 1;

  localparam logic [BW_W-1:0] BL      = BW_W'(BURST_LEN);
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [BW_W-1:0]  bw_cnt_q, bw_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BW_W-1:0]  bwords_q, bwords_d;
  logic [CNT_W-1:0] drained_q, drained_d;

  logic [DW-1:0]    buf0_q, buf0_d;
  logic [DW-1:0]    buf1_q, buf1_d;
  logic [1:0]       buf_cnt_q, buf_cnt_d;

  logic             push;
  logic             pop;

  // Read strobe: only while bursting, with room in the buffer and burst quota
  // left. Held low during reset so a mid-burst reset cannot pop a word that
  // would then be discarded.
  assign rinc = rrst_n && (state_q == ST_BURST) && !rempty &&
                (buf_cnt_q != 2'd2) && (bw_cnt_q < BL);

  assign push = rinc;
  assign pop  = m_valid && m_ready;

  assign m_valid     = (buf_cnt_q != 2'd0);
  assign m_data      = buf0_q;
  assign busy        = (state_q != ST_IDLE);
  assign burst_done  = (state_q == ST_DONE);
  assign burst_words = bwords_q;
  assign drained_cnt = drained_q;

  // Burst sequencing: wait for data, arm the timeout when nearly empty, burst, report.
  always_comb begin
    state_d  = state_q;
    bw_cnt_d = bw_cnt_q;
    timer_d  = timer_q;
    bwords_d = bwords_q;
    case (state_q)
      ST_IDLE: begin
        bw_cnt_d = '0;
        timer_d  = '0;
        if (enable && !rempty && !aempty) begin
          state_d = ST_BURST;
        end else if (enable && !rempty) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        timer_d = timer_q + TW'(1);
        if (!enable || rempty) begin
          state_d = ST_IDLE;
        end else if (!aempty || (timer_q == TO_LAST)) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // enable is deliberately ignored here so a started burst always completes.
        bw_cnt_d = bw_cnt_q + BW_W'(rinc);
        if (bw_cnt_d == BL) begin
          state_d  = ST_DONE;
          bwords_d = bw_cnt_d;
        end else if (rempty && (bw_cnt_q != '0)) begin
          state_d  = ST_DONE;
          bwords_d = bw_cnt_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Two-entry output buffer: head in buf0, simultaneous push/pop keeps one word flowing per cycle.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = rdata;
        end else begin
          buf1_d = rdata;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        // push requires buf_cnt<2 and pop requires buf_cnt>0, so buf_cnt is 1 here.
        buf0_d = rdata;
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase
  end

  // Transfer counter, wraps naturally at 2^CNT_W.
  always_comb begin
    drained_d = drained_q + CNT_W'(pop);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q   <= ST_IDLE;
      bw_cnt_q  <= '0;
      timer_q   <= '0;
      bwords_q  <= '0;
      drained_q <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      buf_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      bw_cnt_q  <= bw_cnt_d;
      timer_q   <= timer_d;
      bwords_q  <= bwords_d;
      drained_q <= drained_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - directed self-checking bench for fifo_rd_drain

module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 16;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          enable;
  logic          m_ready;
  logic          rinc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          busy;
  logic          burst_done;
  logic [2:0]    burst_words;
  logic [CW-1:0] drained_cnt;

  logic          rempty;
  logic          aempty;
  logic [DW-1:0] rdata;

  // FIFO model: show-ahead head word, almost-empty at <= 4 words.
  logic [DW-1:0] mem [0:63];
  logic [5:0]    wr_ptr;
  logic [5:0]    rd_ptr;
  logic [5:0]    fcount;
  logic          fifo_clr;

  assign fcount = wr_ptr - rd_ptr;
  assign rempty = (fcount == 6'd0);
  assign aempty = (fcount <= 6'd4);
  assign rdata  = mem[rd_ptr];

  always #5 rclk = ~rclk;

  always @(posedge rclk) begin
    if (fifo_clr) rd_ptr <= 6'd0;
    else if (rinc) rd_ptr <= rd_ptr + 6'd1;
  end

  fifo_rd_drain #(.DW(DW), .BURST_LEN(BL), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .enable      (enable),
    .rempty      (rempty),
    .aempty      (aempty),
    .rdata       (rdata),
    .rinc        (rinc),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .burst_done  (burst_done),
    .burst_words (burst_words),
    .drained_cnt (drained_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_rinc;
  int cyc;
  logic [DW-1:0] outq[$];
  int            tq[$];
  int            bwq[$];
  int            dq[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the stream at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge rclk);
    cyc++;
    if (rrst_n && m_valid && m_ready) begin
      outq.push_back(m_data);
      tq.push_back(cyc);
    end
    if (burst_done) begin
      bwq.push_back(int'(burst_words));
      dq.push_back(cyc);
    end
    if (rinc) n_rinc++;
    @(posedge rclk);
    #1;
  endtask

  task automatic clear_logs();
    outq.delete();
    tq.delete();
    bwq.delete();
    dq.delete();
    n_rinc = 0;
    cyc    = 0;
  endtask

  // Call with rrst_n low: empties the FIFO model.
  task automatic clear_fifo();
    wr_ptr   = 6'd0;
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + DW'(i);
      wr_ptr      = wr_ptr + 6'd1;
    end
  endtask

  task automatic check_seq(input string tag, input logic [DW-1:0] base, input int n);
    check_val({tag, "_len"}, 32'(outq.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_w%0d", tag, i), 32'(outq[i]), 32'(base + DW'(i)));
    end
  endtask

  initial begin
    int g;
    int bad;
    rrst_n   = 1'b0;
    enable   = 1'b1;
    m_ready  = 1'b1;
    fifo_clr = 1'b0;
    wr_ptr   = 6'd0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    clear_logs();

    // Reset held with data present, then bursting 10 words.
    clear_fifo();
    load(8'h01, 10);
    repeat (3) tick();
    check_val("rst_rinc", 32'(rinc), 32'd0);
    check_val("rst_mvalid", 32'(m_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_drained", 32'(drained_cnt), 32'd0);
    check_val("rst_bwords", 32'(burst_words), 32'd0);
    clear_logs();
    rrst_n = 1'b1;
    #1;
    check_val("rel_rinc_idle", 32'(rinc), 32'd0);
    tick();
    check_val("rel_first_rinc", 32'(rinc), 32'd1);
    repeat (80) tick();
    check_val("b_nbursts", 32'(bwq.size()), 32'd3);
    check_val("b_words0", 32'(bwq[0]), 32'd4);
    check_val("b_words1", 32'(bwq[1]), 32'd4);
    check_val("b_words2", 32'(bwq[2]), 32'd2);
    check_val("b_done0_cyc", 32'(dq[0]), 32'd6);
    check_val("b_done1_cyc", 32'(dq[1]), 32'd12);
    check_val("b_done2_cyc", 32'(dq[2]), 32'd33);
    check_seq("b_data", 8'h01, 10);
    check_val("b_drained", 32'(drained_cnt), 32'd10);
    check_val("b_idle", 32'(busy), 32'd0);

    // Backpressure: buffer fills with two words and holds the head.
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    clear_fifo();
    load(8'h11, 6);
    tick();
    rrst_n = 1'b1;
    clear_logs();
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (m_valid && (m_data != 8'h11)) bad++;
    end
    check_val("bp_nrinc", 32'(n_rinc), 32'd2);
    check_val("bp_rinc_low", 32'(rinc), 32'd0);
    check_val("bp_mvalid", 32'(m_valid), 32'd1);
    check_val("bp_mdata", 32'(m_data), 32'h11);
    check_val("bp_stable", 32'(bad), 32'd0);
    check_val("bp_busy", 32'(busy), 32'd1);
    m_ready = 1'b1;
    repeat (40) tick();
    check_seq("bp_data", 8'h11, 6);
    check_val("bp_rate", 32'(tq[3] - tq[0]), 32'd3);
    check_val("bp_drained", 32'(drained_cnt), 32'd6);

    // enable dropped in the second burst cycle: burst still completes.
    rrst_n = 1'b0;
    clear_fifo();
    load(8'h21, 6);
    tick();
    rrst_n = 1'b1;
    clear_logs();
    g = 0;
    while (!rinc && g < 10) begin
      tick();
      g++;
    end
    check_val("en_start", 32'(rinc), 32'd1);
    tick();
    enable = 1'b0;
    repeat (20) tick();
    check_val("en_nrinc", 32'(n_rinc), 32'd4);
    check_val("en_nbursts", 32'(bwq.size()), 32'd1);
    check_val("en_words", 32'(bwq[0]), 32'd4);
    check_val("en_busy", 32'(busy), 32'd0);
    check_val("en_rinc", 32'(rinc), 32'd0);
    check_val("en_fcount", 32'(fcount), 32'd2);
    check_seq("en_data", 8'h21, 4);

    // Reset after two reads of a burst; draining restarts at word 3.
    enable = 1'b1;
    rrst_n = 1'b0;
    clear_fifo();
    load(8'h31, 6);
    tick();
    rrst_n = 1'b1;
    clear_logs();
    g = 0;
    while (n_rinc < 2 && g < 10) begin
      tick();
      g++;
    end
    check_val("mr_two_reads", 32'(n_rinc), 32'd2);
    rrst_n = 1'b0;
    tick();
    check_val("mr_mvalid", 32'(m_valid), 32'd0);
    check_val("mr_rinc", 32'(rinc), 32'd0);
    check_val("mr_busy", 32'(busy), 32'd0);
    check_val("mr_fcount", 32'(fcount), 32'd4);
    clear_logs();
    rrst_n = 1'b1;
    repeat (40) tick();
    check_seq("mr_data", 8'h33, 4);

    // Counter wrap with a 4-bit drained_cnt.
    rrst_n = 1'b0;
    clear_fifo();
    load(8'h40, 17);
    tick();
    rrst_n = 1'b1;
    clear_logs();
    repeat (120) tick();
    check_val("wr_count", 32'(outq.size()), 32'd17);
    check_val("wr_fcount", 32'(fcount), 32'd0);
    check_val("wr_drained", 32'(drained_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
